// File: rtl/bus_src_arb.sv
// bus_src_arb: selects one of SRCS source channels onto a registered output bus
// with a valid/ready handshake. Selection is explicit (sel) or, when the macro
// BUS_SRC_ARB_RR_EN is defined, optionally round-robin among valid sources.
// Without BUS_SRC_ARB_RR_EN only fixed selection exists and rr_mode is ignored.
module bus_src_arb #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SRCS  = 16,
   parameter int unsigned SELW  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SRCS*WIDTH-1:0]   src_data,
   input  logic [SRCS-1:0]         src_valid,
   output logic [SRCS-1:0]         src_ready,
   input  logic [SELW-1:0]         sel,
   input  logic                    rr_mode,
   output logic [WIDTH-1:0]        bus_data,
   output logic                    bus_valid,
   input  logic                    bus_ready,
   output logic [SELW-1:0]         bus_src
);

   logic            load_en;
   logic            xfer_in;
   logic            fix_vld;
   logic [SELW-1:0] fix_idx;
   logic            gnt_vld;
   logic [SELW-1:0] gnt_idx;
   logic [WIDTH-1:0] gnt_data;

   // Output register can take a new beat when empty or draining this cycle.
   assign load_en = !bus_valid || bus_ready;
   assign xfer_in = gnt_vld && load_en;

   // Fixed-mode grant: out-of-range sel matches no source, so it yields no grant.
   always_comb begin
      fix_vld = 1'b0;
      fix_idx = '0;
      for (int unsigned i = 0; i < SRCS; i++) begin
         if (sel == SELW'(i) && src_valid[i]) begin
            fix_vld = 1'b1;
            fix_idx = SELW'(i);
         end
      end
   end

`ifdef BUS_SRC_ARB_RR_EN
   logic [SELW-1:0] ptr_q;
   logic [SELW-1:0] ptr_nxt;
   logic            hi_vld;
   logic [SELW-1:0] hi_idx;
   logic            lo_vld;
   logic [SELW-1:0] lo_idx;

   // Cyclic search from ptr: lowest valid index >= ptr, else lowest valid overall.
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int i = int'(SRCS) - 1; i >= 0; i--) begin
         if (src_valid[i]) begin
            lo_vld = 1'b1;
            lo_idx = SELW'(i);
            if (SELW'(i) >= ptr_q) begin
               hi_vld = 1'b1;
               hi_idx = SELW'(i);
            end
         end
      end
   end

   // Mode mux between round-robin and fixed grant.
   always_comb begin
      gnt_vld = fix_vld;
      gnt_idx = fix_idx;
      if (rr_mode) begin
         gnt_vld = hi_vld || lo_vld;
         gnt_idx = hi_vld ? hi_idx : lo_idx;
      end
   end

   assign ptr_nxt = (gnt_idx == SELW'(SRCS - 1)) ? '0 : gnt_idx + SELW'(1);

   // Pointer advances past the granted source only on RR transfers; kept otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (xfer_in && rr_mode) begin
         ptr_q <= ptr_nxt;
      end
   end
`else
   logic unused_rr_mode;
   assign unused_rr_mode = rr_mode;
   assign gnt_vld        = fix_vld;
   assign gnt_idx        = fix_idx;
`endif

   // Data of the granted source; src_ready never depends on this path.
   always_comb begin
      gnt_data = '0;
      for (int unsigned i = 0; i < SRCS; i++) begin
         if (gnt_idx == SELW'(i)) begin
            gnt_data = src_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot ready to the granted source; forced low while reset is asserted.
   always_comb begin
      src_ready = '0;
      if (rst_n && xfer_in) begin
         for (int unsigned i = 0; i < SRCS; i++) begin
            if (gnt_idx == SELW'(i)) begin
               src_ready[i] = 1'b1;
            end
         end
      end
   end

   // Output stage: load replaces any draining beat; data/src hold while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_valid <= 1'b0;
         bus_data  <= '0;
         bus_src   <= '0;
      end else if (xfer_in) begin
         bus_valid <= 1'b1;
         bus_data  <= gnt_data;
         bus_src   <= gnt_idx;
      end else if (bus_ready) begin
         bus_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_src_arb.sv
// Scoreboard bench for bus_src_arb: a behavioural model predicts grants and
// queues expected beats; a negedge monitor pops them as the bus hands them off.
module tb_bus_src_arb;
   localparam int W  = 8;
   localparam int N  = 16;
   localparam int SW = 4;
   localparam int N2 = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [N*W-1:0] src_data;
   logic [N-1:0]   src_valid, src_ready;
   logic [SW-1:0]  sel, bus_src;
   logic           rr_mode, bus_valid, bus_ready;
   logic [W-1:0]   bus_data;

   logic [N2*W-1:0] s_data;
   logic [N2-1:0]   s_valid, s_ready;
   logic [SW-1:0]   s_sel, s_bus_src;
   logic            s_rr, s_bus_valid, s_bus_ready;
   logic [W-1:0]    s_bus_data;

   bus_src_arb #(.WIDTH(W), .SRCS(N), .SELW(SW)) u_dut (
      .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
      .src_ready(src_ready), .sel(sel), .rr_mode(rr_mode), .bus_data(bus_data),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_src(bus_src)
   );

   bus_src_arb #(.WIDTH(W), .SRCS(N2), .SELW(SW)) u_small (
      .clk(clk), .rst_n(rst_n), .src_data(s_data), .src_valid(s_valid),
      .src_ready(s_ready), .sel(s_sel), .rr_mode(s_rr), .bus_data(s_bus_data),
      .bus_valid(s_bus_valid), .bus_ready(s_bus_ready), .bus_src(s_bus_src)
   );

`ifdef BUS_SRC_ARB_RR_EN
   localparam bit RR_ON = 1'b1;
`else
   localparam bit RR_ON = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] d;
      int           s;
   } beat_t;

   beat_t exp_q[$];
   int    total = 0;
   int    bad = 0;
   bit    m_valid = 1'b0;
   int    m_ptr = 0;
   bit    last_xfer;
   int    last_g;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference grant straight from the selection rules.
   function automatic void model_grant(output bit gv, output int g);
      gv = 1'b0;
      g  = 0;
      if (RR_ON && rr_mode) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (src_valid[idx] && !gv) begin
               gv = 1'b1;
               g  = idx;
            end
         end
      end else if (int'(sel) < N && src_valid[sel]) begin
         gv = 1'b1;
         g  = int'(sel);
      end
   endfunction

   // One clock cycle: check ready, update model, take the edge, check occupancy.
   task automatic step();
      bit           gv;
      int           g;
      logic [N-1:0] er;
      beat_t        b;
      #1;
      model_grant(gv, g);
      er = '0;
      last_xfer = gv && (!m_valid || bus_ready);
      last_g = g;
      if (last_xfer) er[g] = 1'b1;
      chk("src_ready", src_ready, er);
      if (last_xfer) begin
         b.d = src_data[g*W +: W];
         b.s = g;
         exp_q.push_back(b);
         m_valid = 1'b1;
         if (RR_ON && rr_mode) m_ptr = (g + 1) % N;
      end else if (bus_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("bus_valid", bus_valid, m_valid);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      m_valid = 1'b0;
      m_ptr = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Monitor: the beat on the bus is handed off at the next edge when ready is high.
   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         if (rst_n && bus_valid && bus_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL beat: got data %0h src %0d, expected no beat", bus_data, bus_src);
            end else begin
               b = exp_q.pop_front();
               chk("bus_data", bus_data, b.d);
               chk("bus_src", bus_src, b.s);
            end
         end
      end
   end

   initial begin
      src_data = '0; src_valid = '0; sel = '0; rr_mode = 1'b0; bus_ready = 1'b0;
      s_data = '0; s_valid = '0; s_sel = '0; s_rr = 1'b0; s_bus_ready = 1'b0;

      // Reset values, and no ready while reset is held even with a valid grant.
      #2 rst_n = 1'b0;
      sel = 4'd3;
      src_valid = 16'h0008;
      #2;
      chk("rst_bus_valid", bus_valid, 1'b0);
      chk("rst_bus_data", bus_data, 8'h00);
      chk("rst_bus_src", bus_src, 4'd0);
      chk("rst_src_ready", src_ready, 16'h0000);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Fixed basic, then asynchronous reset with a beat held.
      src_data[3*W +: W] = 8'hA5;
      bus_ready = 1'b1;
      step();
      chk("basic_data", bus_data, 8'hA5);
      chk("basic_src", bus_src, 4'd3);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", bus_valid, 1'b0);
      chk("async_rst_data", bus_data, 8'h00);
      exp_q.delete();
      m_valid = 1'b0;
      m_ptr = 0;
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Back-pressure: beat held, no ready, then drain and refill on the same edge.
      src_data[3*W +: W] = 8'h5A;
      step();
      src_data[3*W +: W] = 8'h77;
      bus_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_hold", bus_data, 8'h5A);
      end
      bus_ready = 1'b1;
      step();
      chk("bp_refill", bus_data, 8'h77);
      src_valid = '0;
      step();

      // Out-of-range select on the 12-source instance.
      s_rr = 1'b0;
      s_bus_ready = 1'b1;
      s_valid = '1;
      for (int i = 0; i < N2; i++) s_data[i*W +: W] = W'(8'h30 + i);
      s_sel = 4'd2;
      @(posedge clk);
      #1;
      chk("oor_load_valid", s_bus_valid, 1'b1);
      chk("oor_load_src", s_bus_src, 4'd2);
      chk("oor_load_data", s_bus_data, 8'h32);
      s_sel = 4'd13;
      #1;
      chk("oor_ready", s_ready, 12'h000);
      @(posedge clk);
      #1;
      chk("oor_drain", s_bus_valid, 1'b0);
      s_valid = '0;

`ifdef BUS_SRC_ARB_RR_EN
      // Round-robin fairness with wrap-around from 15 back to 2.
      do_reset();
      begin
         int seq[6];
         seq = '{2, 5, 15, 2, 5, 15};
         rr_mode = 1'b1;
         bus_ready = 1'b1;
         src_valid = 16'h8024;
         src_data[2*W +: W] = 8'h22;
         src_data[5*W +: W] = 8'h55;
         src_data[15*W +: W] = 8'hFF;
         for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_seq", bus_src, seq[k]);
         end
      end
      // Fixed mode interrupts RR; pointer is retained across it.
      rr_mode = 1'b0;
      sel = 4'd5;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("switch_fixed", bus_src, 4'd5);
      end
      rr_mode = 1'b1;
      src_valid = 16'h0020;
      step();
      chk("rr_ptr6", bus_src, 4'd5);
      rr_mode = 1'b0;
      src_valid = 16'h0024;
      step();
      rr_mode = 1'b1;
      #1;
      chk("rr_resume_ready", src_ready, 16'h0004);
      step();
      chk("rr_resume_src", bus_src, 4'd2);
`else
      // rr_mode is ignored without the round-robin build.
      do_reset();
      rr_mode = 1'b1;
      sel = 4'd7;
      bus_ready = 1'b1;
      src_valid = 16'h0080;
      src_data[7*W +: W] = 8'h7E;
      #1;
      chk("norr_ready", src_ready, 16'h0080);
      step();
      chk("norr_src", bus_src, 4'd7);
`endif

      // Randomized traffic; sources hold their beat until accepted.
      do_reset();
      src_valid = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         bus_ready = ($urandom % 4) != 0;
         if ($urandom % 8 == 0) begin
            sel = SW'($urandom);
            rr_mode = 1'($urandom);
         end
         for (int i = 0; i < N; i++) begin
            if (!src_valid[i]) begin
               src_valid[i] = ($urandom % 3) == 0;
               src_data[i*W +: W] = W'($urandom);
            end
         end
         step();
         if (last_xfer) src_valid[last_g] = 1'b0;
      end

      src_valid = '0;
      bus_ready = 1'b1;
      repeat (3) step();
      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
